// File: rtl/rd_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rd_req_arbiter_pkg
//   Shared definitions for the read-request arbiter slice of the dnnweaver
//   read path:
//     - C_LOG_2 helper macro (ceil(log2(n)))
//     - width derivations for PU ids and per-PU outstanding-beat counters
//     - data-type encodings carried on rd_req_d_type
//     - grant outcome classification used by the arbiter datapath
// -----------------------------------------------------------------------------
`ifndef C_LOG_2
`define C_LOG_2(n) ($clog2(n))
`endif

package rd_req_arbiter_pkg;

  // Data-type encodings of a PU read request.
  typedef enum logic [1:0] {
    D_TYPE_STREAM = 2'd0,
    D_TYPE_BUFFER = 2'd1
  } d_type_e;

  // What a winning request turns into once it has been granted.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,  // nobody granted this cycle
    GNT_ZERO = 2'd1,  // zero-beat request: acked, nothing forwarded
    GNT_DROP = 2'd2,  // request larger than the per-PU budget: acked, dropped
    GNT_FWD  = 2'd3   // normal request: acked and forwarded to read_info
  } grant_kind_e;

  // One extra bit so that out-of-range PU ids can be represented and flagged.
  function automatic int pu_id_width(input int num_pu);
    return `C_LOG_2(num_pu) + 1;
  endfunction

  // Counter must hold the value MAX_OUTST itself.
  function automatic int outst_width(input int max_outst);
    return `C_LOG_2(max_outst + 1);
  endfunction

endpackage

// File: rtl/rd_req_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin selector. The search starts at
//   (last_grant + 1) mod NUM_PU and the first eligible requester wins.
//
//   Ports
//     eligible   in  NUM_PU  requesters allowed to win this cycle
//     last_grant in  IDX_W   index of the previous winner
//     grant      out NUM_PU  one-hot winner (all zero when none)
//     valid      out 1       a winner exists
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_PU = 4,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_PU-1:0] eligible,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [NUM_PU-1:0] grant,
  output logic              valid
);

  always_comb begin
    int tgt;
    grant = '0;
    valid = 1'b0;
    tgt   = 0;
    for (int k = 1; k <= NUM_PU; k++) begin
      // Candidate k steps after the last winner, wrapped into 0..NUM_PU-1.
      tgt = int'(last_grant) + k;
      if (tgt >= NUM_PU) tgt = tgt - NUM_PU;
      for (int j = 0; j < NUM_PU; j++) begin
        if (!valid && (tgt == j) && eligible[j]) begin
          grant[j] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rd_req_arbiter.sv
// -----------------------------------------------------------------------------
// rd_req_arbiter
//   Arbitrates read requests from NUM_PU processing units onto the single
//   read_info request channel. Each PU has a budget of MAX_OUTST beats in
//   flight; a request is only forwarded when it fits in that budget. Returned
//   beats (beat_done) give budget back to their owner.
//
//   Ports
//     clk, resetn          clock, asynchronous active-low reset
//     pu_rd_req            per-PU request level, held until acked
//     pu_rd_req_size       per-PU beat count, PU i at slice i
//     pu_rd_req_d_type     per-PU data type (0 stream, 1 buffer)
//     pu_rd_ack            one-hot, one-cycle accept pulse
//     rd_req               one-cycle request pulse to read_info
//     rd_req_size/_pu_id/_d_type  fields of the forwarded request
//     read_info_full       read_info queue full, blocks new grants
//     beat_done/beat_pu_id one beat delivered and its owner
//     idle                 nothing outstanding and rd_req low
//     err_underflow        sticky: beat for an empty counter or bad id
//     err_oversize         sticky: request larger than MAX_OUTST
// -----------------------------------------------------------------------------
module rd_req_arbiter
  import rd_req_arbiter_pkg::*;
#(
  parameter  int NUM_PU    = 4,
  parameter  int RD_SIZE_W = 20,
  parameter  int D_TYPE_W  = 2,
  parameter  int MAX_OUTST = 64,
  localparam int PU_ID_W   = pu_id_width(NUM_PU),
  localparam int OUT_W     = outst_width(MAX_OUTST)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_PU-1:0]             pu_rd_req,
  input  logic [NUM_PU*RD_SIZE_W-1:0]   pu_rd_req_size,
  input  logic [NUM_PU*D_TYPE_W-1:0]    pu_rd_req_d_type,
  output logic [NUM_PU-1:0]             pu_rd_ack,
  output logic                          rd_req,
  output logic [RD_SIZE_W-1:0]          rd_req_size,
  output logic [PU_ID_W-1:0]            rd_req_pu_id,
  output logic [D_TYPE_W-1:0]           rd_req_d_type,
  input  logic                          read_info_full,
  input  logic                          beat_done,
  input  logic [PU_ID_W-1:0]            beat_pu_id,
  output logic                          idle,
  output logic                          err_underflow,
  output logic                          err_oversize
);

  // Common width for size/budget comparisons so neither side is truncated.
  localparam int CMP_W = (RD_SIZE_W > OUT_W) ? RD_SIZE_W : OUT_W;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_PU-1:0]    pu_rd_ack_q,     pu_rd_ack_d;
  logic                 rd_req_q,        rd_req_d;
  logic [RD_SIZE_W-1:0] rd_req_size_q,   rd_req_size_d;
  logic [PU_ID_W-1:0]   rd_req_pu_id_q,  rd_req_pu_id_d;
  logic [D_TYPE_W-1:0]  rd_req_d_type_q, rd_req_d_type_d;
  logic [PU_ID_W-1:0]   last_grant_q,    last_grant_d;
  logic                 err_underflow_q, err_underflow_d;
  logic                 err_oversize_q,  err_oversize_d;
  logic [OUT_W-1:0]     outst_q [NUM_PU];
  logic [OUT_W-1:0]     outst_d [NUM_PU];

  // ---------------------------------------------------------------------------
  // Per-PU request decode and eligibility
  // ---------------------------------------------------------------------------
  logic [RD_SIZE_W-1:0] req_size [NUM_PU];
  logic [D_TYPE_W-1:0]  req_type [NUM_PU];
  logic [NUM_PU-1:0]    oversize;
  logic [NUM_PU-1:0]    fits;
  logic [NUM_PU-1:0]    eligible;
  logic                 arb_en;

  // A grant is only possible while read_info has room and the previous
  // forwarded request has finished its one-cycle pulse.
  assign arb_en = !read_info_full && !rd_req_q;

  always_comb begin
    for (int i = 0; i < NUM_PU; i++) begin
      req_size[i] = pu_rd_req_size[i*RD_SIZE_W +: RD_SIZE_W];
      req_type[i] = pu_rd_req_d_type[i*D_TYPE_W +: D_TYPE_W];
      oversize[i] = CMP_W'(req_size[i]) > CMP_W'(MAX_OUTST);
      // outst never exceeds MAX_OUTST, so the remaining budget cannot wrap.
      fits[i]     = CMP_W'(req_size[i]) <=
                    (CMP_W'(MAX_OUTST) - CMP_W'(outst_q[i]));
      // Oversize requests must still win arbitration so they can be acked
      // and dropped instead of stalling their PU forever.
      eligible[i] = arb_en && pu_rd_req[i] && (fits[i] || oversize[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin selection
  // ---------------------------------------------------------------------------
  logic [NUM_PU-1:0] grant;
  logic              grant_vld;

  rr_arbiter #(
    .NUM_PU (NUM_PU),
    .IDX_W  (PU_ID_W)
  ) u_rr_arbiter (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .grant      (grant),
    .valid      (grant_vld)
  );

  // ---------------------------------------------------------------------------
  // Winner fields and grant classification
  // ---------------------------------------------------------------------------
  logic [RD_SIZE_W-1:0] sel_size;
  logic [D_TYPE_W-1:0]  sel_type;
  logic [PU_ID_W-1:0]   sel_id;
  logic                 sel_over;
  grant_kind_e          kind;

  always_comb begin
    sel_size = '0;
    sel_type = '0;
    sel_id   = '0;
    sel_over = 1'b0;
    for (int j = 0; j < NUM_PU; j++) begin
      if (grant[j]) begin
        sel_size = req_size[j];
        sel_type = req_type[j];
        sel_id   = PU_ID_W'(j);
        sel_over = oversize[j];
      end
    end

    if (!grant_vld)             kind = GNT_NONE;
    else if (sel_size == '0)    kind = GNT_ZERO;
    else if (sel_over)          kind = GNT_DROP;
    else                        kind = GNT_FWD;
  end

  // ---------------------------------------------------------------------------
  // Returned beats
  // ---------------------------------------------------------------------------
  logic [NUM_PU-1:0] beat_hit;
  logic              beat_bad;

  always_comb begin
    // An id that matches no PU stays "bad"; a matching id is bad only when
    // its counter is already empty.
    beat_bad = beat_done;
    for (int i = 0; i < NUM_PU; i++) begin
      beat_hit[i] = beat_done && (beat_pu_id == PU_ID_W'(i));
      if (beat_hit[i]) beat_bad = (outst_q[i] == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pu_rd_ack_d     = grant_vld ? grant : '0;
    rd_req_d        = (kind == GNT_FWD);
    rd_req_size_d   = rd_req_size_q;
    rd_req_pu_id_d  = rd_req_pu_id_q;
    rd_req_d_type_d = rd_req_d_type_q;
    last_grant_d    = grant_vld ? sel_id : last_grant_q;
    err_oversize_d  = err_oversize_q  || (kind == GNT_DROP);
    err_underflow_d = err_underflow_q || beat_bad;

    if (kind == GNT_FWD) begin
      rd_req_size_d   = sel_size;
      rd_req_pu_id_d  = sel_id;
      rd_req_d_type_d = sel_type;
    end

    // Grant and beat on the same PU both apply (net +size-1). A forwarded
    // size is at most MAX_OUTST, so the narrowing cast is lossless.
    for (int i = 0; i < NUM_PU; i++) begin
      outst_d[i] = outst_q[i];
      if ((kind == GNT_FWD) && grant[i])
        outst_d[i] = outst_d[i] + OUT_W'(sel_size);
      if (beat_hit[i] && (outst_q[i] != '0))
        outst_d[i] = outst_d[i] - OUT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pu_rd_ack_q     <= '0;
      rd_req_q        <= 1'b0;
      rd_req_size_q   <= '0;
      rd_req_pu_id_q  <= '0;
      rd_req_d_type_q <= '0;
      last_grant_q    <= PU_ID_W'(NUM_PU - 1);
      err_underflow_q <= 1'b0;
      err_oversize_q  <= 1'b0;
      for (int i = 0; i < NUM_PU; i++) outst_q[i] <= '0;
    end else begin
      pu_rd_ack_q     <= pu_rd_ack_d;
      rd_req_q        <= rd_req_d;
      rd_req_size_q   <= rd_req_size_d;
      rd_req_pu_id_q  <= rd_req_pu_id_d;
      rd_req_d_type_q <= rd_req_d_type_d;
      last_grant_q    <= last_grant_d;
      err_underflow_q <= err_underflow_d;
      err_oversize_q  <= err_oversize_d;
      for (int i = 0; i < NUM_PU; i++) outst_q[i] <= outst_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic any_outst;

  always_comb begin
    any_outst = 1'b0;
    for (int i = 0; i < NUM_PU; i++) begin
      if (outst_q[i] != '0) any_outst = 1'b1;
    end
  end

  assign pu_rd_ack     = pu_rd_ack_q;
  assign rd_req        = rd_req_q;
  assign rd_req_size   = rd_req_size_q;
  assign rd_req_pu_id  = rd_req_pu_id_q;
  assign rd_req_d_type = rd_req_d_type_q;
  assign err_underflow = err_underflow_q;
  assign err_oversize  = err_oversize_q;
  assign idle          = !any_outst && !rd_req_q;

endmodule

// File: tb/tb_rd_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rd_req_arbiter
//   Directed scenarios followed by randomized traffic for rd_req_arbiter
//   (NUM_PU=4, MAX_OUTST=8). A per-cycle reference model built from the
//   arbitration/budget rules predicts every output.
// -----------------------------------------------------------------------------
module tb_rd_req_arbiter;

  localparam int NUM_PU    = 4;
  localparam int RD_SIZE_W = 20;
  localparam int D_TYPE_W  = 2;
  localparam int MAX_OUTST = 8;
  localparam int PU_ID_W   = 3;

  logic                        clk = 1'b0;
  logic                        resetn = 1'b0;
  logic [NUM_PU-1:0]           pu_rd_req = '0;
  logic [NUM_PU*RD_SIZE_W-1:0] pu_rd_req_size = '0;
  logic [NUM_PU*D_TYPE_W-1:0]  pu_rd_req_d_type = '0;
  logic [NUM_PU-1:0]           pu_rd_ack;
  logic                        rd_req;
  logic [RD_SIZE_W-1:0]        rd_req_size;
  logic [PU_ID_W-1:0]          rd_req_pu_id;
  logic [D_TYPE_W-1:0]         rd_req_d_type;
  logic                        read_info_full = 1'b0;
  logic                        beat_done = 1'b0;
  logic [PU_ID_W-1:0]          beat_pu_id = '0;
  logic                        idle;
  logic                        err_underflow;
  logic                        err_oversize;

  rd_req_arbiter #(
    .NUM_PU    (NUM_PU),
    .RD_SIZE_W (RD_SIZE_W),
    .D_TYPE_W  (D_TYPE_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .pu_rd_req        (pu_rd_req),
    .pu_rd_req_size   (pu_rd_req_size),
    .pu_rd_req_d_type (pu_rd_req_d_type),
    .pu_rd_ack        (pu_rd_ack),
    .rd_req           (rd_req),
    .rd_req_size      (rd_req_size),
    .rd_req_pu_id     (rd_req_pu_id),
    .rd_req_d_type    (rd_req_d_type),
    .read_info_full   (read_info_full),
    .beat_done        (beat_done),
    .beat_pu_id       (beat_pu_id),
    .idle             (idle),
    .err_underflow    (err_underflow),
    .err_oversize     (err_oversize)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  int               m_outst [NUM_PU];
  int               m_last;
  bit               m_rd;
  int               m_size, m_id, m_type;
  logic [NUM_PU-1:0] m_ack;
  bit               m_eu, m_eo;

  function automatic void model_reset();
    for (int i = 0; i < NUM_PU; i++) m_outst[i] = 0;
    m_last = NUM_PU - 1;
    m_rd = 0; m_size = 0; m_id = 0; m_type = 0;
    m_ack = '0; m_eu = 0; m_eo = 0;
  endfunction

  // One clock edge of the rules, evaluated on the inputs present at the edge.
  function automatic void model_step();
    int g, sz, bid;
    if (!resetn) begin
      model_reset();
      return;
    end
    g = -1;
    if (!read_info_full && !m_rd) begin
      for (int k = 1; k <= NUM_PU; k++) begin
        int j;
        j  = (m_last + k) % NUM_PU;
        sz = int'(pu_rd_req_size[j*RD_SIZE_W +: RD_SIZE_W]);
        if (g < 0 && pu_rd_req[j] && (sz > MAX_OUTST || m_outst[j] + sz <= MAX_OUTST))
          g = j;
      end
    end
    if (beat_done) begin
      bid = int'(beat_pu_id);
      if (bid >= NUM_PU || m_outst[bid] == 0) m_eu = 1;
      else m_outst[bid] = m_outst[bid] - 1;
    end
    m_ack = '0;
    m_rd  = 0;
    if (g >= 0) begin
      sz = int'(pu_rd_req_size[g*RD_SIZE_W +: RD_SIZE_W]);
      m_ack[g] = 1'b1;
      m_last   = g;
      if (sz > MAX_OUTST) m_eo = 1;
      else if (sz > 0) begin
        m_rd = 1; m_size = sz; m_id = g;
        m_type = int'(pu_rd_req_d_type[g*D_TYPE_W +: D_TYPE_W]);
        m_outst[g] = m_outst[g] + sz;
      end
    end
  endfunction

  task automatic compare_all();
    bit exp_idle;
    exp_idle = !m_rd;
    for (int i = 0; i < NUM_PU; i++) if (m_outst[i] != 0) exp_idle = 0;
    check("ack", pu_rd_ack, m_ack);
    check("rd_req", rd_req, m_rd);
    check("idle", idle, exp_idle);
    check("err_underflow", err_underflow, m_eu);
    check("err_oversize", err_oversize, m_eo);
    if (m_rd) begin
      check("rd_req_size", rd_req_size, m_size);
      check("rd_req_pu_id", rd_req_pu_id, m_id);
      check("rd_req_d_type", rd_req_d_type, m_type);
    end
  endtask

  // Advance one clock; PUs drop an acked request, beat_done is a pulse.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    for (int i = 0; i < NUM_PU; i++) if (pu_rd_ack[i]) pu_rd_req[i] = 1'b0;
    beat_done = 1'b0;
  endtask

  task automatic set_req(input int pu, input int sz, input int ty);
    pu_rd_req[pu] = 1'b1;
    pu_rd_req_size[pu*RD_SIZE_W +: RD_SIZE_W] = RD_SIZE_W'(sz);
    pu_rd_req_d_type[pu*D_TYPE_W +: D_TYPE_W] = D_TYPE_W'(ty);
  endtask

  task automatic beat(input int pu);
    beat_done  = 1'b1;
    beat_pu_id = PU_ID_W'(pu);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    pu_rd_req = '0;
    beat_done = 1'b0;
    read_info_full = 1'b0;
    #1;
    check("rst_rd_req", rd_req, 0);
    check("rst_fields", {rd_req_size, rd_req_pu_id, rd_req_d_type}, 0);
    check("rst_ack", pu_rd_ack, 0);
    check("rst_idle", idle, 1);
    check("rst_err", {err_underflow, err_oversize}, 0);
    repeat (2) cycle();
    resetn = 1'b1;
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_cyc[$];
    logic [NUM_PU-1:0] ack_vec[$];
    int ids[$];
    bit got;

    model_reset();
    @(negedge clk);
    do_reset();

    // All four PUs request 3 beats together: acks at cycles 1,3,5,7 in order.
    for (int i = 0; i < NUM_PU; i++) set_req(i, 3, i % 2);
    for (int c = 1; c <= 9; c++) begin
      cycle();
      if (pu_rd_ack != '0) begin ack_cyc.push_back(c); ack_vec.push_back(pu_rd_ack); end
      if (rd_req) ids.push_back(int'(rd_req_pu_id));
    end
    check("rr_num_acks", ack_cyc.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < ack_cyc.size()) begin
        check("rr_ack_cycle", ack_cyc[k], 2*k + 1);
        check("rr_ack_pu", ack_vec[k], 4'b0001 << k);
      end
      if (k < ids.size()) check("rr_fwd_id", ids[k], k);
    end
    for (int i = 0; i < NUM_PU; i++) repeat (3) begin beat(i); cycle(); end
    check("rr_drained_idle", idle, 1);

    // read_info_full blocks everything; ack one cycle after full drops.
    do_reset();
    read_info_full = 1'b1;
    set_req(1, 2, 0);
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("full_no_ack", pu_rd_ack, 0);
      check("full_no_rd_req", rd_req, 0);
    end
    read_info_full = 1'b0;
    cycle();
    check("full_ack_after_drop", pu_rd_ack, 4'b0010);

    // Budget: PU2 size 6 forwarded, size 4 waits for two returned beats.
    do_reset();
    set_req(2, 6, 1);
    cycle();
    check("budget_first_fwd", rd_req, 1);
    cycle();
    set_req(2, 4, 0);
    repeat (3) begin cycle(); check("budget_hold0", pu_rd_ack[2], 0); end
    beat(2); cycle();
    repeat (3) begin cycle(); check("budget_hold1", pu_rd_ack[2], 0); end
    beat(2); cycle();
    got = 0;
    for (int c = 0; c < 6 && !got; c++) begin
      cycle();
      if (pu_rd_ack[2]) begin got = 1; check("budget_fwd_size", rd_req_size, 4); end
    end
    check("budget_second_acked", got, 1);

    // Same-cycle grant (size 5) and beat for PU0 at outst=2 -> outst=6.
    do_reset();
    set_req(0, 2, 0);
    cycle(); cycle();
    set_req(0, 5, 0);
    beat(0);
    cycle(); cycle();
    repeat (5) begin beat(0); cycle(); end
    check("net_idle_after5", idle, 0);
    beat(0); cycle();
    check("net_idle_after6", idle, 1);
    check("net_no_underflow", err_underflow, 0);

    // Underflow: bad id, then empty counter; both sticky until reset.
    do_reset();
    beat(6); cycle();
    check("uf_bad_id", err_underflow, 1);
    repeat (3) cycle();
    check("uf_sticky", err_underflow, 1);
    do_reset();
    check("uf_cleared", err_underflow, 0);
    beat(3); cycle();
    check("uf_empty", err_underflow, 1);

    // Oversize drop, exact-budget forward, zero-size ack and priority shift.
    set_req(1, 100, 0);
    cycle();
    check("ovs_ack", pu_rd_ack, 4'b0010);
    check("ovs_no_rd_req", rd_req, 0);
    check("ovs_flag", err_oversize, 1);
    set_req(0, MAX_OUTST, 1);
    cycle();
    check("exact_fwd", rd_req, 1);
    cycle();
    set_req(2, 0, 0);
    cycle();
    check("zero_ack", pu_rd_ack, 4'b0100);
    check("zero_no_rd_req", rd_req, 0);
    set_req(1, 1, 0);
    set_req(3, 1, 0);
    cycle();
    check("zero_moves_priority", pu_rd_ack, 4'b1000);
    repeat (4) cycle();

    // Reset while PU1 has 7 beats outstanding and rd_req is high.
    do_reset();
    set_req(1, 7, 0);
    cycle();
    check("mid_rst_rd_req_high", rd_req, 1);
    do_reset();
    repeat (3) begin
      cycle();
      check("post_rst_no_ack", pu_rd_ack, 0);
      check("post_rst_idle", idle, 1);
    end

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      read_info_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NUM_PU; i++) begin
        if (!pu_rd_req[i] && $urandom_range(0, 2) == 0) begin
          int sz;
          sz = ($urandom_range(0, 39) == 0) ? 100 : int'($urandom_range(0, MAX_OUTST + 1));
          set_req(i, sz, int'($urandom_range(0, 1)));
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 59) == 0) beat(int'($urandom_range(4, 7)));
        else begin
          int st, pick;
          st = int'($urandom_range(0, NUM_PU - 1));
          pick = -1;
          for (int k = 0; k < NUM_PU; k++)
            if (pick < 0 && m_outst[(st + k) % NUM_PU] > 0) pick = (st + k) % NUM_PU;
          if (pick >= 0) beat(pick);
        end
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
